// File: rtl/mux4_rr_sched_pkg.sv
// ============================================================================
// Module   : mux4_rr_sched_pkg
// Brief    : Shared types and helpers for the round-robin 4:1 mux scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux4_rr_sched_pkg;

  localparam int NREQ = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  function automatic logic [NREQ-1:0] onehot2(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Scan from the highest offset down so the lowest offset from start wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] start);
    pick_t      r;
    logic [1:0] k;
    r.found = 1'b0;
    r.idx   = start;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = start + 2'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_sched_dp.sv
// ============================================================================
// Module   : mux4_dp
// Brief    : Combinational DW-wide 4:1 data mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux4_dp #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic [1:0]    sel,
  output logic [DW-1:0] y
);

  always_comb begin
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      2'd3:    y = d;
      default: y = a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_sched.sv
// ============================================================================
// Module   : mux4_rr_sched
// Brief    : Round-robin scheduler for a shared 4:1 mux, burst-limited grants.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [DW-1:0]   c,
  input  logic [DW-1:0]   d,
  input  logic            out_ready,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   out,
  output logic            out_valid,
  output logic            busy
);

  localparam int            c_bw   = $clog2(MAX_BURST) + 1;
  localparam logic [c_bw-1:0] c_last = c_bw'(MAX_BURST - 1);

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [1:0]      r_sel, w_sel_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [c_bw-1:0] r_burst, w_burst_nxt;
  logic [DW-1:0]   r_out, w_out_nxt;
  logic            r_valid, w_valid_nxt;
  logic [DW-1:0]   w_mux;
  pick_t           w_pick_idle;
  pick_t           w_pick_next;

  mux4_dp #(.DW(DW)) u_dp (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (r_sel),
    .y   (w_mux)
  );

  // Handover search excludes the current owner and starts just past it.
  assign w_pick_idle = rr_pick(req, r_ptr);
  assign w_pick_next = rr_pick(req & ~onehot2(r_sel), r_sel + 2'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst;
    w_out_nxt   = r_out;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_idle.found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = onehot2(w_pick_idle.idx);
          w_sel_nxt   = w_pick_idle.idx;
          w_burst_nxt = '0;
        end
      end
      GRANT: begin
        if (!req[r_sel]) begin
          w_ptr_nxt   = r_sel + 2'd1;
          w_burst_nxt = '0;
          if (w_pick_next.found) begin
            w_gnt_nxt = onehot2(w_pick_next.idx);
            w_sel_nxt = w_pick_next.idx;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (out_ready) begin
          w_out_nxt   = w_mux;
          w_valid_nxt = 1'b1;
          if (r_burst == c_last) begin
            w_burst_nxt = '0;
            if (w_pick_next.found) begin
              w_ptr_nxt = r_sel + 2'd1;
              w_gnt_nxt = onehot2(w_pick_next.idx);
              w_sel_nxt = w_pick_next.idx;
            end
          end else begin
            w_burst_nxt = r_burst + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_burst <= w_burst_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign busy      = (r_state == GRANT);

endmodule

`default_nettype wire
